// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial controller/datapath pair.
//   - 3-bit state encodings of the control unit (also exported on state_dbg)
//   - operand / result widths and the largest operand whose factorial fits
package factorial_pkg;

  localparam int N_W   = 4;   // operand n width
  localparam int OUT_W = 32;  // product / factorial_out width
  localparam int N_MAX = 12;  // 12! is the largest factorial that fits in OUT_W bits

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_MULT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

endpackage

// File: rtl/factorial_dp.sv
// Factorial datapath: down-counter and product register driven by factorial_cu.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (counter only)
//   n               operand
//   prod_mux_sel    0 = load constant 1, 1 = load prod * cnt
//   prod_reg_ld     product register load enable
//   cnt_ld, cnt_en  counter parallel load / decrement enable
//   out_mux_sel     1 = product onto factorial_out, 0 = zero
//   a_gt_b          counter > 1
//   err             n > N_MAX (combinational on n)
//   factorial_out   result
module factorial_dp
  import factorial_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_W-1:0]   n,
  input  logic             prod_mux_sel,
  input  logic             prod_reg_ld,
  input  logic             cnt_ld,
  input  logic             cnt_en,
  input  logic             out_mux_sel,
  output logic             a_gt_b,
  output logic             err,
  output logic [OUT_W-1:0] factorial_out
);

  logic [N_W-1:0]   cnt_q;
  logic [N_W-1:0]   cnt_d;
  logic [OUT_W-1:0] prod_q;
  logic [OUT_W-1:0] prod_d;
  logic [OUT_W-1:0] mul_res;

  // 0! = 1! so n = 0 loads 1 and the controller sees no multiply to do.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_ld) begin
      cnt_d = (n == '0) ? N_W'(1) : n;
    end else if (cnt_en) begin
      cnt_d = cnt_q - N_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Operands up to N_MAX keep the product inside OUT_W bits.
  assign mul_res = prod_q * OUT_W'(cnt_q);

  always_comb begin
    prod_d = prod_q;
    if (prod_reg_ld) begin
      prod_d = prod_mux_sel ? mul_res : OUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  assign a_gt_b        = (cnt_q > N_W'(1));
  assign err           = (n > N_W'(N_MAX));
  assign factorial_out = out_mux_sel ? prod_q : '0;

endmodule

// File: rtl/factorial_cu.sv
// Factorial control unit: Moore FSM sequencing the factorial datapath.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   go              level start request
//   a_gt_b          datapath status: down-counter > 1
//   err             datapath status: operand n > 12 (sampled only in IDLE)
//   prod_mux_sel    0 = constant 1, 1 = multiplier result into product register
//   prod_reg_ld     product register load enable
//   cnt_ld, cnt_en  down-counter parallel load / count enable
//   out_mux_sel     1 = product onto factorial_out, 0 = zero
//   done, error     result (or rejection) valid / operand rejected
//   busy            computation in progress
//   state_dbg       current state encoding
module factorial_cu
  import factorial_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       a_gt_b,
  input  logic       err,
  output logic       prod_mux_sel,
  output logic       prod_reg_ld,
  output logic       cnt_ld,
  output logic       cnt_en,
  output logic       out_mux_sel,
  output logic       done,
  output logic       error,
  output logic       busy,
  output logic [2:0] state_dbg
);

  logic [2:0] state_q;
  logic [2:0] state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output is a pure decode of state_q, so reset clears them at once.
  always_comb begin
    state_d      = S_IDLE;  // unused encodings fall back to IDLE
    prod_mux_sel = 1'b0;
    prod_reg_ld  = 1'b0;
    cnt_ld       = 1'b0;
    cnt_en       = 1'b0;
    out_mux_sel  = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    busy         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = err ? S_ERROR : S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        cnt_ld       = 1'b1;
        prod_reg_ld  = 1'b1;
        prod_mux_sel = 1'b0;
        busy         = 1'b1;
        state_d      = S_CHECK;
      end

      S_CHECK: begin
        busy    = 1'b1;
        state_d = a_gt_b ? S_MULT : S_DONE;
      end

      S_MULT: begin
        prod_mux_sel = 1'b1;
        prod_reg_ld  = 1'b1;
        cnt_en       = 1'b1;
        busy         = 1'b1;
        state_d      = S_CHECK;
      end

      // Holding go does not restart; a new run needs go low first.
      S_DONE: begin
        done        = 1'b1;
        out_mux_sel = 1'b1;
        state_d     = go ? S_DONE : S_IDLE;
      end

      S_ERROR: begin
        done        = 1'b1;
        error       = 1'b1;
        out_mux_sel = 1'b0;
        state_d     = go ? S_ERROR : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_factorial_cu.sv
module tb_factorial_cu;
  import factorial_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic [N_W-1:0]   n_in;
  logic             a_gt_b;
  logic             err;
  logic             prod_mux_sel;
  logic             prod_reg_ld;
  logic             cnt_ld;
  logic             cnt_en;
  logic             out_mux_sel;
  logic             done;
  logic             error;
  logic             busy;
  logic [2:0]       state_dbg;
  logic [OUT_W-1:0] factorial_out;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int en_cnt;
  int ld_cnt;
  int mult_ld_cnt;

  always #5 clk = ~clk;

  factorial_cu dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .a_gt_b       (a_gt_b),
    .err          (err),
    .prod_mux_sel (prod_mux_sel),
    .prod_reg_ld  (prod_reg_ld),
    .cnt_ld       (cnt_ld),
    .cnt_en       (cnt_en),
    .out_mux_sel  (out_mux_sel),
    .done         (done),
    .error        (error),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  factorial_dp u_dp (
    .clk           (clk),
    .rst           (rst),
    .n             (n_in),
    .prod_mux_sel  (prod_mux_sel),
    .prod_reg_ld   (prod_reg_ld),
    .cnt_ld        (cnt_ld),
    .cnt_en        (cnt_en),
    .out_mux_sel   (out_mux_sel),
    .a_gt_b        (a_gt_b),
    .err           (err),
    .factorial_out (factorial_out)
  );

  // Pulse counters: each clock edge closes one cycle of control outputs.
  always @(posedge clk) begin
    if (cnt_en)                      en_cnt++;
    if (cnt_ld)                      ld_cnt++;
    if (prod_reg_ld && prod_mux_sel) mult_ld_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint fact(input int k);
    longint r = 1;
    for (int i = 2; i <= k; i++) r = r * i;
    return r;
  endfunction

  task automatic clear_counts();
    en_cnt = 0; ld_cnt = 0; mult_ld_cnt = 0;
  endtask

  // mode 0: go held until done then a few extra cycles; mode 1: one-cycle go pulse
  task automatic run_calc(input int n, input int mode);
    int  edges;
    int  eff;
    int  extra;
    bit  ended;
    bit  exp_err;
    exp_err = (n > N_MAX);
    eff     = (n < 1) ? 1 : n;
    @(negedge clk);
    n_in = N_W'(n);
    go   = 1'b1;
    clear_counts();
    edges = 0;
    ended = 1'b0;
    while (!ended && edges < 80) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (mode == 1) go = 1'b0;
      if (done) ended = 1'b1;
    end
    check($sformatf("done_reached n=%0d", n), 32'(ended), 32'd1);
    if (exp_err) begin
      check($sformatf("err_latency n=%0d", n), edges, 1);
      check($sformatf("err_state n=%0d", n), 32'(state_dbg), 32'(S_ERROR));
      check($sformatf("err_flag n=%0d", n), 32'(error), 32'd1);
      check($sformatf("err_out n=%0d", n), factorial_out, 32'd0);
      check($sformatf("err_no_ld n=%0d", n), ld_cnt, 0);
    end else begin
      check($sformatf("latency n=%0d", n), edges, 2 * eff + 1);
      check($sformatf("done_state n=%0d", n), 32'(state_dbg), 32'(S_DONE));
      check($sformatf("no_error n=%0d", n), 32'(error), 32'd0);
      check($sformatf("result n=%0d", n), factorial_out, 32'(fact(n)));
      check($sformatf("cnt_en_pulses n=%0d", n), en_cnt, eff - 1);
      check($sformatf("mult_ld_pulses n=%0d", n), mult_ld_cnt, eff - 1);
      check($sformatf("cnt_ld_pulses n=%0d", n), ld_cnt, 1);
    end
    if (mode == 0) begin
      extra = $urandom_range(1, 4);
      repeat (extra) @(negedge clk);
      check($sformatf("held_done n=%0d", n), 32'(done), 32'd1);
      check($sformatf("no_restart n=%0d", n), ld_cnt, exp_err ? 0 : 1);
      go = 1'b0;
    end
    @(negedge clk);
    check($sformatf("back_idle n=%0d", n), 32'(state_dbg), 32'(S_IDLE));
    check($sformatf("done_cleared n=%0d", n), 32'(done), 32'd0);
  endtask

  initial begin
    int mult_seen;
    int guard;
    rst  = 1'b1;
    go   = 1'b0;
    n_in = '0;
    clear_counts();
    #1;
    check("reset_state", 32'(state_dbg), 32'(S_IDLE));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_calc(5, 0);
    run_calc(0, 0);
    run_calc(12, 0);
    run_calc(13, 0);
    run_calc(1, 1);
    run_calc(7, 1);

    // Reset during the third MULT cycle of n=6
    @(negedge clk);
    n_in = N_W'(6);
    go   = 1'b1;
    mult_seen = 0;
    guard = 0;
    while (mult_seen < 3 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (state_dbg == S_MULT) mult_seen++;
    end
    check("reach_third_mult", mult_seen, 3);
    #1 rst = 1'b1;
    #1;
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_prod_ld", 32'(prod_reg_ld), 32'd0);
    check("rst_out", factorial_out, 32'd0);
    go = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(state_dbg), 32'(S_IDLE));
    run_calc(3, 0);

    // go held for 40 cycles: exactly one computation
    @(negedge clk);
    n_in = N_W'(4);
    go   = 1'b1;
    clear_counts();
    repeat (40) @(negedge clk);
    check("hold40_done", 32'(done), 32'd1);
    check("hold40_result", factorial_out, 32'd24);
    check("hold40_one_load", ld_cnt, 1);
    go = 1'b0;
    @(negedge clk);
    check("hold40_idle", 32'(state_dbg), 32'(S_IDLE));

    for (int i = 0; i < 16; i++) begin
      run_calc($urandom_range(0, 15), $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
